// File: rtl/rt_job_scheduler.sv
// Ray-tracing job scheduler. It splits one job into tiles, hands tile indices
// to idle tracer cores in round-robin order and counts completions. When the
// job finishes it reports a one-cycle end_rt pulse with an 8-bit status word.
// A watchdog abandons the job if no core completes for too long.
module rt_job_scheduler #(
  parameter int              NUM_CORES      = 4,
  parameter int              TILE_W         = 16,
  parameter int              TO_W           = 24,
  parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_rt,
  input  logic [TILE_W-1:0]           num_tiles,
  output logic                        end_rt,
  output logic [7:0]                  end_rtstat,
  output logic                        busy,
  output logic [NUM_CORES-1:0]        core_start,
  output logic [NUM_CORES*TILE_W-1:0] core_tile,
  input  logic [NUM_CORES-1:0]        core_done,
  input  logic [NUM_CORES-1:0]        core_err
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

  state_t                state, state_d;
  logic [TILE_W-1:0]     num_q, num_d;
  logic [TILE_W-1:0]     next_tile, next_d;
  logic [TILE_W-1:0]     done_cnt, done_d;
  logic [NUM_CORES-1:0]  busy_mask, mask_d;
  logic [PTR_W-1:0]      rr_ptr, rr_d;
  logic [TO_W-1:0]       wdog, wdog_d;
  logic                  err_flag, err_d;
  logic                  spur_flag, spur_d;
  logic                  to_flag, to_d;
  logic                  busy_d;
  logic                  end_d;
  logic [7:0]            stat_d;

  logic                  grant_vld;
  logic [PTR_W-1:0]      grant_idx;
  logic                  grant_now;
  logic [PTR_W:0]        srch_sum;
  logic [PTR_W-1:0]      srch_idx;

  logic [NUM_CORES-1:0]  done_vld;
  logic [NUM_CORES-1:0]  spur_hit;
  logic [TILE_W-1:0]     done_inc;
  logic                  any_done;
  logic                  timeout_hit;

  // Find the first idle core at or after the round-robin pointer, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    srch_sum  = '0;
    srch_idx  = '0;
    for (int j = 0; j < NUM_CORES; j++) begin
      srch_sum = {1'b0, rr_ptr} + (PTR_W+1)'(j);
      if (srch_sum >= (PTR_W+1)'(NUM_CORES))
        srch_sum = srch_sum - (PTR_W+1)'(NUM_CORES);
      srch_idx = srch_sum[PTR_W-1:0];
      if (!grant_vld && !busy_mask[srch_idx]) begin
        grant_vld = 1'b1;
        grant_idx = srch_idx;
      end
    end
  end

  // Classify this cycle's completion pulses and count the genuine ones.
  always_comb begin
    done_vld    = core_done & busy_mask;
    spur_hit    = core_done & ~busy_mask;
    any_done    = |done_vld;
    done_inc    = '0;
    for (int i = 0; i < NUM_CORES; i++)
      done_inc = done_inc + TILE_W'(done_vld[i]);
    timeout_hit = (TIMEOUT_CYCLES != '0) && !any_done && (wdog <= TO_W'(1));
  end

  // Next-state and next-value logic for the job sequencer.
  always_comb begin
    state_d   = state;
    num_d     = num_q;
    next_d    = next_tile;
    done_d    = done_cnt;
    mask_d    = busy_mask;
    rr_d      = rr_ptr;
    wdog_d    = wdog;
    err_d     = err_flag;
    spur_d    = spur_flag;
    to_d      = to_flag;
    busy_d    = busy;
    end_d     = 1'b0;
    stat_d    = end_rtstat;
    grant_now = 1'b0;

    case (state)
      IDLE: begin
        if (start_rt) begin
          num_d   = num_tiles;
          next_d  = '0;
          done_d  = '0;
          err_d   = 1'b0;
          spur_d  = 1'b0;
          to_d    = 1'b0;
          wdog_d  = TIMEOUT_CYCLES;
          busy_d  = 1'b1;
          state_d = (num_tiles == '0) ? DONE : DISPATCH;
        end
      end

      DISPATCH, DRAIN: begin
        if (|spur_hit)
          spur_d = 1'b1;
        if (timeout_hit) begin
          to_d    = 1'b1;
          wdog_d  = '0;
          state_d = DONE;
        end else begin
          mask_d = busy_mask & ~done_vld;
          done_d = done_cnt + done_inc;
          if (|(done_vld & core_err))
            err_d = 1'b1;
          if (any_done)
            wdog_d = TIMEOUT_CYCLES;
          else if (wdog != '0)
            wdog_d = wdog - TO_W'(1);
          if (state == DISPATCH) begin
            if (grant_vld && (next_tile != num_q)) begin
              grant_now         = 1'b1;
              mask_d[grant_idx] = 1'b1;
              next_d            = next_tile + TILE_W'(1);
              rr_d              = (grant_idx == PTR_W'(NUM_CORES - 1)) ? '0 : grant_idx + PTR_W'(1);
              if (next_d == num_q)
                state_d = DRAIN;
            end
          end else if (done_d == num_q) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        end_d   = 1'b1;
        busy_d  = 1'b0;
        stat_d  = {3'b000, spur_flag, (num_q == '0), to_flag, err_flag,
                   ~(err_flag | to_flag | spur_flag)};
        mask_d  = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      num_q      <= '0;
      next_tile  <= '0;
      done_cnt   <= '0;
      busy_mask  <= '0;
      rr_ptr     <= '0;
      wdog       <= '0;
      err_flag   <= 1'b0;
      spur_flag  <= 1'b0;
      to_flag    <= 1'b0;
      busy       <= 1'b0;
      end_rt     <= 1'b0;
      end_rtstat <= '0;
      core_start <= '0;
      core_tile  <= '0;
    end else begin
      state      <= state_d;
      num_q      <= num_d;
      next_tile  <= next_d;
      done_cnt   <= done_d;
      busy_mask  <= mask_d;
      rr_ptr     <= rr_d;
      wdog       <= wdog_d;
      err_flag   <= err_d;
      spur_flag  <= spur_d;
      to_flag    <= to_d;
      busy       <= busy_d;
      end_rt     <= end_d;
      end_rtstat <= stat_d;
      core_start <= grant_now ? (NUM_CORES'(1) << grant_idx) : '0;
      if (grant_now)
        core_tile[int'(grant_idx)*TILE_W +: TILE_W] <= next_tile;
    end
  end

endmodule

// File: tb/tb_rt_job_scheduler.sv
// Testbench for rt_job_scheduler: emulated tracer cores, a job-level
// reference model that predicts dispatches and completions, and a scoreboard
// monitor that checks every core_start / end_rt the DUT presents.
module tb_rt_job_scheduler;

  localparam int NC = 4;
  localparam int TW = 16;
  localparam int TO = 50;

  logic             clk = 1'b0;
  logic             reset;
  logic             start_rt;
  logic [TW-1:0]    num_tiles;
  logic             end_rt;
  logic [7:0]       end_rtstat;
  logic             busy;
  logic [NC-1:0]    core_start;
  logic [NC*TW-1:0] core_tile;
  logic [NC-1:0]    core_done = '0;
  logic [NC-1:0]    core_err = '0;

  int errors = 0;
  int checks = 0;

  rt_job_scheduler #(
    .NUM_CORES(NC), .TILE_W(TW), .TO_W(24), .TIMEOUT_CYCLES(24'd50)
  ) dut (
    .clk(clk), .reset(reset), .start_rt(start_rt), .num_tiles(num_tiles),
    .end_rt(end_rt), .end_rtstat(end_rtstat), .busy(busy),
    .core_start(core_start), .core_tile(core_tile),
    .core_done(core_done), .core_err(core_err)
  );

  always #5 clk = ~clk;

  // Emulated tracer cores: each completes lat[i] cycles after its start
  // (lat 0 = never), flagging an error on tile err_tile.
  int            lat[NC];
  int            cnt[NC];
  int            ctile[NC];
  int            err_tile = -1;
  logic [NC-1:0] inj_mask = '0;

  always begin
    @(negedge clk);
    #1;
    core_done = '0;
    core_err  = '0;
    if (!reset) begin
      for (int i = 0; i < NC; i++) cnt[i] = 0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            core_done[i] = 1'b1;
            core_err[i]  = (ctile[i] == err_tile);
          end
        end
      end
      for (int i = 0; i < NC; i++) begin
        if (core_start[i]) begin
          ctile[i] = int'(core_tile[i*TW +: TW]);
          cnt[i]   = lat[i];
        end
      end
      core_done = core_done | inj_mask;
      inj_mask  = '0;
    end
  end

  // Reference model: tracks the job as tiles handed out, cores occupied and
  // the cycle by which progress must happen, and queues expected events.
  typedef struct {
    int         cyc;
    bit         is_end;
    int         core;
    int         tile;
    logic [7:0] stat;
  } ev_t;

  ev_t expq[$];
  ev_t mev;
  int  cyc = 0;
  bit  m_active, m_finishing, m_err, m_spur, m_to;
  int  m_n, m_next, m_done, m_rr, m_deadline;
  bit  m_core_busy[NC];

  always @(posedge clk) begin
    int completed;
    int g;
    bit was_busy[NC];
    cyc++;
    if (!reset) begin
      m_active = 0; m_finishing = 0; m_err = 0; m_spur = 0; m_to = 0;
      m_n = 0; m_next = 0; m_done = 0; m_rr = 0;
      for (int i = 0; i < NC; i++) m_core_busy[i] = 0;
    end else if (m_finishing) begin
      mev.cyc = cyc; mev.is_end = 1; mev.core = 0; mev.tile = 0;
      mev.stat = {3'b000, m_spur, (m_n == 0), m_to, m_err, !(m_err || m_to || m_spur)};
      expq.push_back(mev);
      m_active = 0;
      m_finishing = 0;
      for (int i = 0; i < NC; i++) m_core_busy[i] = 0;
    end else if (!m_active) begin
      if (start_rt) begin
        m_active = 1; m_n = int'(num_tiles); m_next = 0; m_done = 0;
        m_err = 0; m_spur = 0; m_to = 0;
        m_deadline = cyc + TO;
        if (m_n == 0) m_finishing = 1;
      end
    end else begin
      completed = 0;
      g = -1;
      for (int i = 0; i < NC; i++) begin
        was_busy[i] = m_core_busy[i];
        if (core_done[i]) begin
          if (was_busy[i]) begin
            completed++;
            if (core_err[i]) m_err = 1;
          end else begin
            m_spur = 1;
          end
        end
      end
      if (m_next < m_n)
        for (int j = 0; j < NC; j++)
          if (g < 0 && !was_busy[(m_rr + j) % NC]) g = (m_rr + j) % NC;
      if (completed == 0 && cyc >= m_deadline) begin
        m_to = 1;
        m_finishing = 1;
      end else begin
        for (int i = 0; i < NC; i++)
          if (core_done[i] && was_busy[i]) m_core_busy[i] = 0;
        m_done += completed;
        if (completed > 0) m_deadline = cyc + TO;
        if (g >= 0) begin
          mev.cyc = cyc; mev.is_end = 0; mev.core = g; mev.tile = m_next; mev.stat = 8'h00;
          expq.push_back(mev);
          m_core_busy[g] = 1;
          m_next++;
          m_rr = (g + 1) % NC;
        end
        if (m_next == m_n && m_done == m_n) m_finishing = 1;
      end
    end
  end

  // Scoreboard monitor: pops and compares on every DUT output event.
  always @(posedge clk) begin
    ev_t e;
    #1;
    checks++;
    if (busy !== m_active) begin
      errors++;
      $display("[TB] FAIL busy @%0d got=%0b exp=%0b", cyc, busy, m_active);
    end
    for (int i = 0; i < NC; i++) begin
      if (core_start[i] === 1'b1) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("[TB] FAIL dispatch @%0d got core=%0d tile=%0d exp=nothing", cyc, i, core_tile[i*TW +: TW]);
        end else begin
          e = expq.pop_front();
          if (e.cyc != cyc || e.is_end || e.core != i || e.tile != int'(core_tile[i*TW +: TW])) begin
            errors++;
            $display("[TB] FAIL dispatch @%0d got core=%0d tile=%0d exp cyc=%0d end=%0b core=%0d tile=%0d",
                     cyc, i, core_tile[i*TW +: TW], e.cyc, e.is_end, e.core, e.tile);
          end
        end
      end
    end
    if (end_rt === 1'b1) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("[TB] FAIL end_rt @%0d got stat=%02h exp=nothing", cyc, end_rtstat);
      end else begin
        e = expq.pop_front();
        if (e.cyc != cyc || !e.is_end || e.stat !== end_rtstat) begin
          errors++;
          $display("[TB] FAIL end_rt @%0d got stat=%02h exp cyc=%0d end=%0b stat=%02h",
                   cyc, end_rtstat, e.cyc, e.is_end, e.stat);
        end
      end
    end
    while (expq.size() > 0 && expq[0].cyc <= cyc) begin
      e = expq.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missing_event @%0d exp cyc=%0d end=%0b core=%0d tile=%0d stat=%02h",
               cyc, e.cyc, e.is_end, e.core, e.tile, e.stat);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int n);
    @(negedge clk);
    start_rt  = 1'b1;
    num_tiles = TW'(n);
    @(negedge clk);
    start_rt  = 1'b0;
  endtask

  task automatic waitEnd(input string name, input int budget);
    bit seen = 0;
    for (int k = 0; k < budget; k++) begin
      if (end_rt === 1'b1) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL %s_timeout got=no end_rt exp=end_rt within %0d cycles", name, budget);
    end
    @(negedge clk);
  endtask

  task automatic setLat(input int a, input int b, input int c, input int d);
    lat[0] = a; lat[1] = b; lat[2] = c; lat[3] = d;
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_end_rt"}, 64'(end_rt), 64'd0);
    checkOutput({tag, "_stat"}, 64'(end_rtstat), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_core_start"}, 64'(core_start), 64'd0);
    checkOutput({tag, "_core_tile"}, 64'(core_tile), 64'd0);
  endtask

  // Global bound so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout got=still running exp=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Directed and randomized job sequence.
  initial begin
    bit found;
    reset = 1'b0; start_rt = 1'b0; num_tiles = '0;
    setLat(5, 5, 5, 5);
    repeat (3) @(negedge clk);
    checkIdleZero("reset");
    reset = 1'b1;

    // Basic job of ten tiles.
    applyStimulus(10);
    waitEnd("basic", 300);
    checkOutput("basic_stat", 64'(end_rtstat), 64'h01);
    checkOutput("basic_busy_after", 64'(busy), 64'd0);

    // Empty job: end_rt exactly two cycles after start_rt.
    applyStimulus(0);
    checkOutput("empty_end_early", 64'(end_rt), 64'd0);
    @(negedge clk);
    checkOutput("empty_end", 64'(end_rt), 64'd1);
    checkOutput("empty_stat", 64'(end_rtstat), 64'h09);
    @(negedge clk);
    checkOutput("empty_end_pulse", 64'(end_rt), 64'd0);

    // Error on tile 2 plus a spurious done from idle core 3.
    err_tile = 2;
    applyStimulus(10);
    inj_mask = 4'b1000;
    waitEnd("errspur", 300);
    checkOutput("errspur_stat", 64'(end_rtstat), 64'h12);
    err_tile = -1;

    // Watchdog: core 1 never completes; a normal job follows.
    setLat(5, 0, 5, 5);
    applyStimulus(4);
    waitEnd("timeout", 300);
    checkOutput("timeout_stat", 64'(end_rtstat), 64'h04);
    setLat(5, 5, 5, 5);
    applyStimulus(6);
    waitEnd("after_to", 300);
    checkOutput("after_to_stat", 64'(end_rtstat), 64'h01);

    // Done coinciding with round-robin turn, plus an ignored start_rt.
    setLat(3, 3, 3, 3);
    applyStimulus(12);
    repeat (4) @(negedge clk);
    start_rt = 1'b1; num_tiles = 16'd3;
    @(negedge clk);
    start_rt = 1'b0;
    waitEnd("coincide", 300);
    checkOutput("coincide_stat", 64'(end_rtstat), 64'h01);

    // Staggered latencies so two cores finish in the same cycle.
    setLat(6, 5, 2, 4);
    applyStimulus(9);
    waitEnd("double", 300);
    checkOutput("double_stat", 64'(end_rtstat), 64'h01);

    // Randomized jobs.
    for (int r = 0; r < 8; r++) begin
      setLat($urandom_range(1, 9), $urandom_range(1, 9), $urandom_range(1, 9), $urandom_range(1, 9));
      applyStimulus($urandom_range(1, 20));
      waitEnd("random", 600);
      checkOutput("random_stat", 64'(end_rtstat), 64'h01);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset in the middle of dispatch once tile 3 is outstanding.
    setLat(5, 5, 5, 5);
    applyStimulus(8);
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      for (int i = 0; i < NC; i++)
        if (core_start[i] && core_tile[i*TW +: TW] == 16'd3) found = 1;
      if (!found) @(negedge clk);
    end
    checkOutput("tile3_seen", 64'(found), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checkIdleZero("midreset");
    found = 0;
    repeat (20) begin
      @(negedge clk);
      if (end_rt) found = 1;
    end
    checkOutput("midreset_no_end", 64'(found), 64'd0);
    applyStimulus(2);
    waitEnd("post_reset", 200);
    checkOutput("post_reset_stat", 64'(end_rtstat), 64'h01);

    repeat (5) @(negedge clk);
    checkOutput("queue_drained", 64'(expq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rt_job_scheduler.md
Name: rt_job_scheduler

Overview:
- Sequences one ray-tracing job, split into tiles, across NUM_CORES identical tracer cores.
- Accepts the one-cycle `start_rt` pulse from the Avalon control slave and hands tile indices out to idle cores round-robin.
- Counts completions, then returns a one-cycle `end_rt` pulse plus an 8-bit `end_rtstat` status word back to that slave.
- Sits between the host-facing control slave and the tracer core array.

Parameters:
- NUM_CORES, 4, number of tracer cores (1..8).
- TILE_W, 16, width of tile count and tile index.
- TO_W, 24, width of the watchdog counter.
- TIMEOUT_CYCLES, 24'd10_000_000, cycles allowed without any completion; 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset; 0 = reset asserted.
- start_rt  in  1  one-cycle job start pulse.
- num_tiles  in  TILE_W  tiles in the job; sampled only on an accepted start_rt.
- end_rt  out  1  one-cycle job-finished pulse.
- end_rtstat  out  8  job status; valid while end_rt=1 and held afterwards.
- busy  out  1  high from the accepted start_rt until end_rt.
- core_start  out  NUM_CORES  one-hot, one-cycle dispatch pulse per core.
- core_tile  out  NUM_CORES*TILE_W  tile index per core; slice i is valid while core_start[i]=1.
- core_done  in  NUM_CORES  one-cycle completion pulse per core.
- core_err  in  NUM_CORES  error qualifier; sampled only with core_done[i].

Behaviour:
- Reset (reset=0 at a clk edge) puts every output at 0: end_rt, end_rtstat, busy, core_start, core_tile. It also clears all internal counters, the busy mask, the round-robin pointer (points at core 0) and status flags, and forces state IDLE.
- Reset mid-job aborts the job silently: no end_rt, and core_start drops the next cycle.
- State machine: IDLE, DISPATCH, DRAIN, DONE.
- IDLE:
  - On start_rt=1, latch num_tiles, clear next_tile, done_cnt and flags, reload the watchdog, set busy=1.
  - If num_tiles==0, go to DONE; otherwise go to DISPATCH.
- start_rt while not IDLE is ignored, with no status effect.
- DISPATCH:
  - Each cycle, at most one core is granted: the first core with busy_mask=0, searching from rr_ptr upward and wrapping.
  - Grant to core i means: core_start[i]=1 and core_tile[i]=next_tile (registered, one cycle); busy_mask[i] set; next_tile+1; rr_ptr=i+1 mod NUM_CORES.
  - No grant is made if all cores are busy.
  - Once next_tile==latched num_tiles, go to DRAIN.
- Tile indices are issued strictly in order 0..num_tiles-1, exactly once each.
- core_done[i] with busy_mask[i]=1 does four things: clears busy_mask[i], increments done_cnt, reloads the watchdog, and sets err_flag if core_err[i]=1.
- Done and grant in the same cycle:
  - A core whose done arrives in cycle t is evaluated as busy for grants in cycle t.
  - It is eligible from t+1.
  - Multiple core_done bits in the same cycle are all counted.
- core_done[i] with busy_mask[i]=0 is ignored for counting but sets spur_flag.
- DRAIN:
  - Wait until done_cnt==latched num_tiles, then go to DONE.
  - The done_cnt check includes completions arriving that same cycle (next-state value).
- Watchdog (TIMEOUT_CYCLES≠0):
  - Decrements each cycle in DISPATCH and DRAIN.
  - On reaching 0, set to_flag and go to DONE immediately, abandoning outstanding tiles.
  - After a timeout, busy_mask is cleared on entry to IDLE; late core_done pulses then set nothing.
- DONE (exactly one cycle):
  - end_rt=1, busy=0 from the next cycle.
  - end_rtstat is registered and presented in the same cycle as end_rt. Bits:
    - [0] ok = no error, timeout or spurious flag.
    - [1] err_flag.
    - [2] to_flag.
    - [3] empty job (num_tiles==0).
    - [4] spur_flag.
    - [7:5] = 0.
  - Next state is IDLE.
- Latency:
  - start_rt sampled at edge k → busy=1 after edge k.
  - First core_start high after edge k+1.
  - Last tile's core_done sampled at edge m → end_rt high after edge m+1.
- Arithmetic: done_cnt and next_tile are TILE_W bits and never exceed num_tiles. Watchdog arithmetic is TO_W bits, unsigned, with no wrap.

Test Plan:
- Basic job: NUM_CORES=4, num_tiles=10, each core pulses done 5 cycles after its start.
  - core_start goes to cores 0,1,2,3 on consecutive cycles with tiles 0..3.
  - Tiles 4..9 are reissued round-robin as cores free up.
  - One end_rt pulse arrives 1 cycle after the 10th done, with end_rtstat=8'h01.
- Empty job: num_tiles=0.
  - No core_start.
  - end_rt two cycles after start_rt, with end_rtstat=8'h09.
- Error plus spurious done: core 2 returns core_err=1 on tile 2, and core 3 pulses done while idle.
  - The job still completes all 10 tiles.
  - end_rtstat=8'h12.
- Timeout: TIMEOUT_CYCLES=50, core 1 never completes, num_tiles=4.
  - end_rt arrives 50 cycles after the last completion, with end_rtstat=8'h04.
  - A second job then dispatches normally starting at tile 0.
- Simultaneous events:
  - Core 0 done in the same cycle core 0 would be next in the round-robin: no grant to core 0 that cycle, grant the next cycle.
  - start_rt during a job: ignored.
  - Two dones in one cycle: done_cnt +2.
- Reset mid-job: assert reset=0 for 1 cycle during DISPATCH with tile 3 outstanding.
  - All outputs 0 and no end_rt.
  - A new start_rt with num_tiles=2 completes with end_rtstat=8'h01.
